if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding request/grant/response instruction-memory port.
- Presents {pc, instr} with a one-cycle-per-instruction valid to IF/ID, and redirects the PC on taken branches resolved in ID.
- Emits the IF/ID flush and raises a fetch-stall whenever no new instruction is available.

---
 rtl/if_fetch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues one request at a time on a req/gnt/rvalid instruction-memory port,
//   and presents {pc, instr} with a one-cycle valid. Taken branches resolved
//   in ID redirect the PC. A fetched word that arrives while ID is stalled is
//   parked in a one-entry skid register.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          run enable, sampled only while idle
//   stall_i          hazard stall from ID (also gates IF/ID)
//   branch_i         taken branch/jump resolved in ID this cycle
//   branch_target_i  redirect PC, valid with branch_i
//   imem_req_o       memory request
//   imem_addr_o      request address (current PC)
//   imem_gnt_i       request accepted
//   imem_rvalid_i    read data valid
//   imem_rdata_i     instruction word
//   pc_o             PC of the presented instruction
//   instr_o          presented instruction
//   instr_valid_o    new instruction presented this cycle
//   flush_o          IF/ID flush (same-cycle copy of branch_i)
//   fetch_stall_o    no instruction available (inverse of instr_valid_o)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        flush_o,
    output logic        fetch_stall_o
);

    localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    state_e      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] req_pc_r, req_pc_s;
    logic [31:0] skid_pc_r, skid_pc_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic [31:0] out_pc_r, out_pc_s;
    logic [31:0] out_instr_r, out_instr_s;
    logic        out_valid_r, out_valid_s;
    logic        load_s;
    logic [31:0] load_pc_s;
    logic [31:0] load_instr_s;
    logic [31:0] next_seq_pc_s;

    // Next-state, PC and output-register load decisions.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        req_pc_s     = req_pc_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        load_s       = 1'b0;
        load_pc_s    = 32'h0000_0000;
        load_instr_s = 32'h0000_0000;
        // Sequential successor wraps naturally at 2^32.
        next_seq_pc_s = req_pc_r + PC_STEP_W;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (branch_i) begin
                    pc_s = branch_target_i;
                    // A request granted in the same cycle is now stale.
                    if (imem_gnt_i) begin
                        state_s = ST_DROP;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (imem_gnt_i) begin
                    req_pc_s = pc_r;
                    state_s  = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (branch_i) begin
                    pc_s = branch_target_i;
                    // Response in the branch cycle is discarded on the spot;
                    // otherwise wait for it in DROP so it is never presented.
                    if (imem_rvalid_i) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else if (imem_rvalid_i) begin
                    pc_s = next_seq_pc_s;
                    if (stall_i) begin
                        skid_pc_s    = req_pc_r;
                        skid_instr_s = imem_rdata_i;
                        state_s      = ST_HOLD;
                    end else begin
                        load_s       = 1'b1;
                        load_pc_s    = req_pc_r;
                        load_instr_s = imem_rdata_i;
                        state_s      = ST_REQ;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (branch_i) begin
                    pc_s    = branch_target_i;
                    state_s = ST_REQ;
                end else if (!stall_i) begin
                    load_s       = 1'b1;
                    load_pc_s    = skid_pc_r;
                    load_instr_s = skid_instr_r;
                    state_s      = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (branch_i) begin
                    pc_s = branch_target_i;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_rvalid_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output register: load wins, otherwise hold under stall, else clear valid.
    always_comb begin
        out_pc_s    = out_pc_r;
        out_instr_s = out_instr_r;
        out_valid_s = 1'b0;
        if (load_s) begin
            out_pc_s    = load_pc_s;
            out_instr_s = load_instr_s;
            out_valid_s = 1'b1;
        end else if (stall_i && !branch_i) begin
            out_valid_s = out_valid_r;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            req_pc_r     <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
            out_pc_r     <= 32'h0000_0000;
            out_instr_r  <= 32'h0000_0000;
            out_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            req_pc_r     <= req_pc_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            out_pc_r     <= out_pc_s;
            out_instr_r  <= out_instr_s;
            out_valid_r  <= out_valid_s;
        end
    end

    assign imem_req_o    = (state_r == ST_REQ);
    assign imem_addr_o   = pc_r;
    assign pc_o          = out_pc_r;
    assign instr_o       = out_instr_r;
    assign instr_valid_o = out_valid_r;
    assign flush_o       = branch_i;
    assign fetch_stall_o = !out_valid_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        flush_o;
    logic        fetch_stall_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .flush_o(flush_o),
        .fetch_stall_o(fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit t, input bit b, input bit g,
                         input bit v, input logic [31:0] tgt, input logic [31:0] d);
        rst_i = r; start_i = s; stall_i = t; branch_i = b;
        imem_gnt_i = g; imem_rvalid_i = v; branch_target_i = tgt; imem_rdata_i = d;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit r, s, t, b, g, v;
        logic [31:0] tgt, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit t, bit b, bit g, bit v,
                                logic [31:0] tgt, logic [31:0] rd, logic er,
                                logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
        vec_t x;
        x.r = r; x.s = s; x.t = t; x.b = b; x.g = g; x.v = v;
        x.tgt = tgt; x.rdata = rd; x.e_req = er; x.e_addr = ea;
        x.e_valid = ev; x.e_pc = ep; x.e_instr = ei;
        return x;
    endfunction

    vec_t tbl[27];

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; bit keep; } txn_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } skid_t;
    txn_t  outq[$];
    skid_t skq[$];
    bit          m_run;
    logic [31:0] m_pc, m_out_pc, m_out_instr;
    logic        m_out_valid;

    function automatic bit m_requesting();
        return m_run && (outq.size() == 0) && (skq.size() == 0);
    endfunction

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        txn_t  t;
        skid_t k;
        bit    load;
        logic [31:0] lp, li;
        bool_req: begin end
        if (rst_i) begin
            outq.delete(); skq.delete();
            m_run = 1'b0; m_pc = RST_PC;
            m_out_pc = 32'h0; m_out_instr = 32'h0; m_out_valid = 1'b0;
        end else if (!m_run) begin
            if (start_i) m_run = 1'b1;
        end else if (branch_i) begin
            if (outq.size() > 0 && imem_rvalid_i) begin
                void'(outq.pop_front());
            end else if (outq.size() > 0) begin
                outq[0].keep = 1'b0;
            end else if (m_requesting() && imem_gnt_i) begin
                t.pc = m_pc; t.keep = 1'b0; outq.push_back(t);
            end
            skq.delete();
            m_pc = branch_target_i;
            m_out_valid = 1'b0;
        end else begin
            load = 1'b0; lp = 32'h0; li = 32'h0;
            if (skq.size() > 0) begin
                if (!stall_i) begin
                    load = 1'b1; lp = skq[0].pc; li = skq[0].instr;
                    skq.delete();
                end
            end else if (outq.size() > 0) begin
                if (imem_rvalid_i) begin
                    t = outq.pop_front();
                    if (t.keep) begin
                        m_pc = t.pc + STEP;
                        if (stall_i) begin
                            k.pc = t.pc; k.instr = imem_rdata_i; skq.push_back(k);
                        end else begin
                            load = 1'b1; lp = t.pc; li = imem_rdata_i;
                        end
                    end
                end
            end else if (m_requesting() && imem_gnt_i) begin
                t.pc = m_pc; t.keep = 1'b1; outq.push_back(t);
            end
            if (load) begin
                m_out_valid = 1'b1; m_out_pc = lp; m_out_instr = li;
            end else if (!stall_i) begin
                m_out_valid = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset / stream / stall / branch-in-WAIT / branch+rvalid / wrap / reset-in-WAIT.
        tbl[0]  = mk(0,1,0,0,0,0, 32'h0, 32'h0,        0, 32'h100, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h100, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0,0,0,0,0,1, 32'h0, 32'hA0,       0, 32'h100, 0, 32'h0, 32'h0);
        tbl[3]  = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h104, 1, 32'h100, 32'hA0);
        tbl[4]  = mk(0,0,0,0,0,1, 32'h0, 32'hA1,       0, 32'h104, 0, 32'h100, 32'hA0);
        tbl[5]  = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h108, 1, 32'h104, 32'hA1);
        tbl[6]  = mk(0,0,1,0,0,1, 32'h0, 32'hA2,       0, 32'h108, 0, 32'h104, 32'hA1);
        tbl[7]  = mk(0,0,1,0,1,0, 32'h0, 32'h0,        0, 32'h10C, 0, 32'h104, 32'hA1);
        tbl[8]  = mk(0,0,1,0,0,0, 32'h0, 32'h0,        0, 32'h10C, 0, 32'h104, 32'hA1);
        tbl[9]  = mk(0,0,0,0,0,0, 32'h0, 32'h0,        0, 32'h10C, 0, 32'h104, 32'hA1);
        tbl[10] = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h10C, 1, 32'h108, 32'hA2);
        tbl[11] = mk(0,0,0,1,0,0, 32'h200, 32'h0,      0, 32'h10C, 0, 32'h108, 32'hA2);
        tbl[12] = mk(0,0,0,0,0,0, 32'h0, 32'h0,        0, 32'h200, 0, 32'h108, 32'hA2);
        tbl[13] = mk(0,0,0,0,0,1, 32'h0, 32'hDEAD,     0, 32'h200, 0, 32'h108, 32'hA2);
        tbl[14] = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h200, 0, 32'h108, 32'hA2);
        tbl[15] = mk(0,0,0,0,0,1, 32'h0, 32'hB0,       0, 32'h200, 0, 32'h108, 32'hA2);
        tbl[16] = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h204, 1, 32'h200, 32'hB0);
        tbl[17] = mk(0,0,0,1,0,1, 32'hFFFF_FFFC, 32'hBAD, 0, 32'h204, 0, 32'h200, 32'hB0);
        tbl[18] = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h200, 32'hB0);
        tbl[19] = mk(0,0,0,0,0,1, 32'h0, 32'hC0,       0, 32'hFFFF_FFFC, 0, 32'h200, 32'hB0);
        tbl[20] = mk(0,0,0,0,0,0, 32'h0, 32'h0,        1, 32'h0, 1, 32'hFFFF_FFFC, 32'hC0);
        tbl[21] = mk(0,0,0,0,1,0, 32'h0, 32'h0,        1, 32'h0, 0, 32'hFFFF_FFFC, 32'hC0);
        tbl[22] = mk(1,0,0,0,0,0, 32'h0, 32'h0,        0, 32'h0, 0, 32'hFFFF_FFFC, 32'hC0);
        tbl[23] = mk(0,0,0,0,0,1, 32'h0, 32'hEE,       0, 32'h100, 0, 32'h0, 32'h0);
        tbl[24] = mk(0,0,0,0,0,0, 32'h0, 32'h0,        0, 32'h100, 0, 32'h0, 32'h0);
        tbl[25] = mk(0,1,0,0,0,0, 32'h0, 32'h0,        0, 32'h100, 0, 32'h0, 32'h0);
        tbl[26] = mk(0,0,0,0,0,0, 32'h0, 32'h0,        1, 32'h100, 0, 32'h0, 32'h0);

        // Two reset edges to establish a known state.
        @(negedge clk_i);
        drive(1,0,0,0,0,0, 32'h0, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk_i);
            drive(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].b, tbl[i].g, tbl[i].v, tbl[i].tgt, tbl[i].rdata);
            #1;
            check("tbl_req",   i, {31'd0, imem_req_o},    {31'd0, tbl[i].e_req});
            check("tbl_addr",  i, imem_addr_o,            tbl[i].e_addr);
            check("tbl_valid", i, {31'd0, instr_valid_o}, {31'd0, tbl[i].e_valid});
            check("tbl_pc",    i, pc_o,                   tbl[i].e_pc);
            check("tbl_instr", i, instr_o,                tbl[i].e_instr);
            check("tbl_flush", i, {31'd0, flush_o},       {31'd0, tbl[i].b});
            check("tbl_fstall",i, {31'd0, fetch_stall_o}, {31'd0, !tbl[i].e_valid});
            @(posedge clk_i);
        end

        // Randomised run against the transaction-level model.
        @(negedge clk_i);
        drive(1,0,0,0,0,0, 32'h0, 32'h0);
        @(posedge clk_i);
        model_edge();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                              : ($urandom() & 32'hFFFF_FFFC),
                  $urandom());
            #1;
            check("rnd_req",   c, {31'd0, imem_req_o},    {31'd0, m_requesting()});
            check("rnd_addr",  c, imem_addr_o,            m_pc);
            check("rnd_valid", c, {31'd0, instr_valid_o}, {31'd0, m_out_valid});
            check("rnd_pc",    c, pc_o,                   m_out_pc);
            check("rnd_instr", c, instr_o,                m_out_instr);
            check("rnd_flush", c, {31'd0, flush_o},       {31'd0, branch_i});
            check("rnd_fstall",c, {31'd0, fetch_stall_o}, {31'd0, !m_out_valid});
            @(posedge clk_i);
            model_edge();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
